// File: rtl/gdsp_pkg.sv
// ============================================================================
// Module : gdsp_pkg
// Brief  : Shared DSP-domain constants, button event type and default noise LUT.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package gdsp_pkg;

    localparam int CLK_DSP_HZ        = 27_000_000;
    localparam int DEBOUNCE_20MS_CYC = CLK_DSP_HZ / 50;
    localparam int LONG_1S_CYC       = CLK_DSP_HZ;
    localparam int NOISE_MAG_WIDTH   = 8;

    // Entry 0 sits in the LSBs: {100, 50, 20, 0}
    localparam logic [4*NOISE_MAG_WIDTH-1:0] NOISE_LEVEL_LUT =
        {8'd100, 8'd50, 8'd20, 8'd0};

    typedef struct packed {
        logic press;
        logic release_;
        logic long_;
        logic repeat_;
    } btn_evt_t;

    function automatic int cnt_width(input int max_cyc);
        return $clog2(max_cyc) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module : btn_debounce
// Brief  : One button: 2-FF sync, debounce, IDLE/HELD/LONG classifier, events.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btn_debounce
    import gdsp_pkg::*;
#(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DEBOUNCE_CYC = DEBOUNCE_20MS_CYC,
    parameter int LONG_CYC     = LONG_1S_CYC,
    parameter int REPEAT_CYC   = LONG_1S_CYC / 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     pin,
    output logic     stable,
    output btn_evt_t evt
);

    localparam int DB_W     = cnt_width(DEBOUNCE_CYC);
    localparam int HOLD_MAX = (REPEAT_CYC > LONG_CYC) ? REPEAT_CYC : LONG_CYC;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);

    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);
    localparam logic              PIN_IDLE    = ACTIVE_LOW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } btn_state_t;

    logic              sync_meta;
    logic              sync_pin;
    logic              pressed;
    logic [DB_W-1:0]   db_cnt;
    btn_state_t        state;
    btn_state_t        state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;
    btn_evt_t          evt_next;

    // Synchroniser resets to the released pin level so a held button is re-debounced.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= PIN_IDLE;
            sync_pin  <= PIN_IDLE;
        end else begin
            sync_meta <= pin;
            sync_pin  <= sync_meta;
        end
    end

    assign pressed = sync_pin ^ PIN_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (pressed != stable) begin
            if (db_cnt == DB_LAST) begin
                stable <= pressed;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            evt      <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            evt      <= evt_next;
        end
    end

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        evt_next      = '0;
        case (state)
            ST_IDLE: begin
                hold_cnt_next = '0;
                if (stable) begin
                    state_next     = ST_HELD;
                    evt_next.press = 1'b1;
                end
            end
            ST_HELD: begin
                if (!stable) begin
                    state_next        = ST_IDLE;
                    hold_cnt_next     = '0;
                    evt_next.release_ = 1'b1;
                end else if (hold_cnt == LONG_LAST) begin
                    state_next     = ST_LONG;
                    hold_cnt_next  = '0;
                    evt_next.long_ = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt + 1'b1;
                end
            end
            ST_LONG: begin
                if (!stable) begin
                    state_next        = ST_IDLE;
                    hold_cnt_next     = '0;
                    evt_next.release_ = 1'b1;
                end else if (REPEAT_CYC > 0) begin
                    if (hold_cnt == REPEAT_LAST) begin
                        hold_cnt_next    = '0;
                        evt_next.repeat_ = 1'b1;
                    end else begin
                        hold_cnt_next = hold_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next    = ST_IDLE;
                hold_cnt_next = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ui_level_ctrl.sv
// ============================================================================
// Module : ui_level_ctrl
// Brief  : Button-driven level stepper with combo reset and noise LUT lookup.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ui_level_ctrl
    import gdsp_pkg::*;
#(
    parameter int NUM_BTN        = 2,
    parameter bit BTN_ACTIVE_LOW = 1'b1,
    parameter int DEBOUNCE_CYC   = DEBOUNCE_20MS_CYC,
    parameter int LONG_CYC       = LONG_1S_CYC,
    parameter int REPEAT_CYC     = LONG_1S_CYC / 4,
    parameter int NUM_LEVELS     = 4,
    parameter bit WRAP           = 1'b1,
    parameter int DEFAULT_LEVEL  = 0,
    parameter logic [NUM_LEVELS*NOISE_MAG_WIDTH-1:0] LEVEL_TABLE = NOISE_LEVEL_LUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_BTN-1:0]            btn_raw,
    output logic [NUM_BTN-1:0]            btn_stable,
    output logic [NUM_BTN-1:0]            press_evt,
    output logic [NUM_BTN-1:0]            release_evt,
    output logic [NUM_BTN-1:0]            long_evt,
    output logic [NUM_BTN-1:0]            repeat_evt,
    output logic [$clog2(NUM_LEVELS)-1:0] level,
    output logic [NOISE_MAG_WIDTH-1:0]    noise_magnitude,
    output logic                          level_changed
);

    localparam int LEVEL_W = $clog2(NUM_LEVELS);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_DEF = LEVEL_W'(DEFAULT_LEVEL);

    btn_evt_t           evt [NUM_BTN];
    logic               step_up;
    logic               step_down;
    logic               both_held;
    logic               combo;
    logic [LEVEL_W-1:0] level_next;

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
            btn_debounce #(
                .ACTIVE_LOW   (BTN_ACTIVE_LOW),
                .DEBOUNCE_CYC (DEBOUNCE_CYC),
                .LONG_CYC     (LONG_CYC),
                .REPEAT_CYC   (REPEAT_CYC)
            ) u_btn (
                .clk    (clk),
                .rst    (rst),
                .pin    (btn_raw[i]),
                .stable (btn_stable[i]),
                .evt    (evt[i])
            );
            assign press_evt[i]   = evt[i].press;
            assign release_evt[i] = evt[i].release_;
            assign long_evt[i]    = evt[i].long_;
            assign repeat_evt[i]  = evt[i].repeat_;
        end
    endgenerate

    assign step_up = press_evt[0] | repeat_evt[0];

    generate
        if (NUM_BTN >= 2) begin : g_pair
            assign step_down = press_evt[1] | repeat_evt[1];
            assign both_held = btn_stable[0] & btn_stable[1];
            assign combo     = (long_evt[0] & btn_stable[1]) | (long_evt[1] & btn_stable[0]);
        end else begin : g_single
            assign step_down = 1'b0;
            assign both_held = 1'b0;
            assign combo     = 1'b0;
        end
    endgenerate

    // Combo reset wins over stepping; stepping is frozen while both buttons are down.
    always_comb begin
        level_next = level;
        if (combo) begin
            level_next = LEVEL_DEF;
        end else if (!both_held && step_up && !step_down) begin
            if (level == LEVEL_MAX) begin
                level_next = WRAP ? '0 : LEVEL_MAX;
            end else begin
                level_next = level + 1'b1;
            end
        end else if (!both_held && step_down && !step_up) begin
            if (level == '0) begin
                level_next = WRAP ? LEVEL_MAX : '0;
            end else begin
                level_next = level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level           <= LEVEL_DEF;
            noise_magnitude <= LEVEL_TABLE[DEFAULT_LEVEL*NOISE_MAG_WIDTH +: NOISE_MAG_WIDTH];
            level_changed   <= 1'b0;
        end else begin
            level           <= level_next;
            noise_magnitude <= LEVEL_TABLE[int'(level_next)*NOISE_MAG_WIDTH +: NOISE_MAG_WIDTH];
            level_changed   <= (level_next != level);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ui_level_ctrl.sv
// ============================================================================
// Module : tb_ui_level_ctrl
// Brief  : Self-checking bench for ui_level_ctrl (wrapping and saturating copies).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ui_level_ctrl;
    import gdsp_pkg::*;

    localparam int DEB  = 8;
    localparam int LONG = 40;
    localparam int REP  = 10;
    localparam int NL   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_raw = 2'b11;

    always #5 clk = ~clk;

    logic [1:0] stable_w, press_w, rel_w, long_w, rep_w;
    logic [1:0] level_w;
    logic [7:0] noise_w;
    logic       chg_w;
    logic [1:0] stable_s, press_s, rel_s, long_s, rep_s;
    logic [1:0] level_s;
    logic [7:0] noise_s;
    logic       chg_s;

    ui_level_ctrl #(
        .NUM_BTN(2), .BTN_ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(DEB), .LONG_CYC(LONG),
        .REPEAT_CYC(REP), .NUM_LEVELS(NL), .WRAP(1'b1), .DEFAULT_LEVEL(0)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_stable(stable_w),
        .press_evt(press_w), .release_evt(rel_w), .long_evt(long_w), .repeat_evt(rep_w),
        .level(level_w), .noise_magnitude(noise_w), .level_changed(chg_w)
    );

    ui_level_ctrl #(
        .NUM_BTN(2), .BTN_ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(DEB), .LONG_CYC(LONG),
        .REPEAT_CYC(REP), .NUM_LEVELS(NL), .WRAP(1'b0), .DEFAULT_LEVEL(0)
    ) dut_sat (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_stable(stable_s),
        .press_evt(press_s), .release_evt(rel_s), .long_evt(long_s), .repeat_evt(rep_s),
        .level(level_s), .noise_magnitude(noise_s), .level_changed(chg_s)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: debounce as a run of consecutive disagreeing samples,
    // events from "cycles held since press", level as modular/clamped arithmetic.
    int         lut [NL] = '{0, 20, 50, 100};
    logic [1:0] m_s1, m_s2, m_stable, m_press, m_rel, m_long, m_rep;
    logic [1:0] m_chg;
    int         m_run  [2];
    int         m_held [2];
    int         m_lvl  [2];
    logic       m_up, m_dn, m_both, m_combo;
    int         m_nxt;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_s1 = '0; m_s2 = '0; m_stable = '0;
                m_press = '0; m_rel = '0; m_long = '0; m_rep = '0; m_chg = '0;
                for (int b = 0; b < 2; b++) begin
                    m_run[b] = 0; m_held[b] = -1; m_lvl[b] = 0;
                end
            end else begin
                m_up    = m_press[0] | m_rep[0];
                m_dn    = m_press[1] | m_rep[1];
                m_both  = m_stable[0] & m_stable[1];
                m_combo = (m_long[0] & m_stable[1]) | (m_long[1] & m_stable[0]);
                for (int k = 0; k < 2; k++) begin
                    m_nxt = m_lvl[k];
                    if (m_combo)
                        m_nxt = 0;
                    else if (!m_both && m_up && !m_dn)
                        m_nxt = (k == 0) ? (m_lvl[k] + 1) % NL
                                         : ((m_lvl[k] < NL - 1) ? m_lvl[k] + 1 : m_lvl[k]);
                    else if (!m_both && m_dn && !m_up)
                        m_nxt = (k == 0) ? (m_lvl[k] + NL - 1) % NL
                                         : ((m_lvl[k] > 0) ? m_lvl[k] - 1 : 0);
                    m_chg[k] = (m_nxt != m_lvl[k]);
                    m_lvl[k] = m_nxt;
                end
                for (int b = 0; b < 2; b++) begin
                    m_press[b] = 1'b0; m_rel[b] = 1'b0; m_long[b] = 1'b0; m_rep[b] = 1'b0;
                    if (m_stable[b]) begin
                        if (m_held[b] < 0) begin
                            m_held[b]  = 0;
                            m_press[b] = 1'b1;
                        end else begin
                            m_held[b] = m_held[b] + 1;
                            if (m_held[b] == LONG) m_long[b] = 1'b1;
                            if (m_held[b] > LONG && ((m_held[b] - LONG) % REP) == 0) m_rep[b] = 1'b1;
                        end
                    end else if (m_held[b] >= 0) begin
                        m_rel[b]  = 1'b1;
                        m_held[b] = -1;
                    end
                    if (m_s2[b] != m_stable[b]) begin
                        m_run[b] = m_run[b] + 1;
                        if (m_run[b] == DEB) begin
                            m_stable[b] = ~m_stable[b];
                            m_run[b]    = 0;
                        end
                    end else begin
                        m_run[b] = 0;
                    end
                    m_s2[b] = m_s1[b];
                    m_s1[b] = ~btn_raw[b];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("w_stable",  int'(stable_w), int'(m_stable));
            check("w_press",   int'(press_w),  int'(m_press));
            check("w_release", int'(rel_w),    int'(m_rel));
            check("w_long",    int'(long_w),   int'(m_long));
            check("w_repeat",  int'(rep_w),    int'(m_rep));
            check("w_level",   int'(level_w),  m_lvl[0]);
            check("w_noise",   int'(noise_w),  lut[m_lvl[0]]);
            check("w_changed", int'(chg_w),    int'(m_chg[0]));
            check("s_stable",  int'(stable_s), int'(m_stable));
            check("s_press",   int'(press_s),  int'(m_press));
            check("s_release", int'(rel_s),    int'(m_rel));
            check("s_long",    int'(long_s),   int'(m_long));
            check("s_repeat",  int'(rep_s),    int'(m_rep));
            check("s_level",   int'(level_s),  m_lvl[1]);
            check("s_noise",   int'(noise_s),  lut[m_lvl[1]]);
            check("s_changed", int'(chg_s),    int'(m_chg[1]));
        end
    end

    int chg_cnt_w, chg_cnt_s, p0, r0, lat;
    bit found;

    task automatic clr_counts();
        chg_cnt_w = 0; chg_cnt_s = 0; p0 = 0; r0 = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (chg_w)      chg_cnt_w++;
            if (chg_s)      chg_cnt_s++;
            if (press_w[0]) p0++;
            if (rel_w[0])   r0++;
        end
    endtask

    task automatic tap(input int b, input int n, input int gap);
        btn_raw[b] = 1'b0;
        tick(n);
        btn_raw[b] = 1'b1;
        tick(gap);
    endtask

    initial begin
        clr_counts();
        tick(1);
        cmp_on = 1'b1;
        check("rst_level",  int'(level_w),  0);
        check("rst_noise",  int'(noise_w),  0);
        check("rst_stable", int'(stable_w), 0);
        check("rst_chg",    int'(chg_w),    0);
        tick(2);
        rst = 1'b0;
        tick(3);

        // Clean press: press_evt 2+8+1 edges after the pin edge, level one edge later
        clr_counts();
        btn_raw[0] = 1'b0;
        lat = 0; found = 1'b0;
        for (int i = 1; i <= 40 && !found; i++) begin
            tick(1);
            if (press_w[0]) begin
                lat = i; found = 1'b1;
            end
        end
        check("t1_press_latency", lat, 11);
        tick(1);
        check("t1_level", int'(level_w), 1);
        check("t1_noise", int'(noise_w), 20);
        tick(8);
        btn_raw[0] = 1'b1;
        tick(30);
        check("t1_release_cnt", r0, 1);
        check("t1_chg_cnt", chg_cnt_w, 1);

        // Glitch shorter than the debounce window
        clr_counts();
        tap(0, 5, 25);
        check("t2_press_cnt", p0, 0);
        check("t2_chg_cnt", chg_cnt_w, 0);
        check("t2_level", int'(level_w), 1);

        // Down to 0, then long hold with repeats
        tap(1, 20, 30);
        check("t3_start_w", int'(level_w), 0);
        check("t3_start_s", int'(level_s), 0);
        clr_counts();
        btn_raw[0] = 1'b0;
        tick(90);
        btn_raw[0] = 1'b1;
        tick(30);
        check("t3_chg_w", chg_cnt_w, 5);
        check("t3_level_w", int'(level_w), 1);
        check("t3_chg_s", chg_cnt_s, 3);
        check("t3_level_s", int'(level_s), 3);

        // Saturation at both ends
        clr_counts();
        tap(0, 20, 30);
        check("t4_sat_top", int'(level_s), 3);
        check("t4_sat_top_chg", chg_cnt_s, 0);
        check("t4_wrap_up", int'(level_w), 2);
        tap(1, 20, 30);
        tap(1, 20, 30);
        tap(1, 20, 30);
        clr_counts();
        tap(1, 20, 30);
        check("t4_sat_bot", int'(level_s), 0);
        check("t4_sat_bot_chg", chg_cnt_s, 0);
        check("t4_wrap_level", int'(level_w), 2);

        // Combo: both held past LONG from level 2
        clr_counts();
        btn_raw = 2'b00;
        tick(60);
        btn_raw = 2'b11;
        tick(30);
        check("t5_level_w", int'(level_w), 0);
        check("t5_chg_w", chg_cnt_w, 1);
        check("t5_chg_s", chg_cnt_s, 0);

        // Reset mid-LONG with the pin still held
        tap(0, 20, 30);
        clr_counts();
        btn_raw[0] = 1'b0;
        tick(55);
        check("t6_pre_level", int'(level_w), 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_rst_level",  int'(level_w),  0);
        check("t6_rst_noise",  int'(noise_w),  0);
        check("t6_rst_stable", int'(stable_w), 0);
        clr_counts();
        tick(20);
        check("t6_fresh_press", p0, 1);
        check("t6_no_release", r0, 0);
        check("t6_level", int'(level_w), 1);
        btn_raw[0] = 1'b1;
        tick(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
